// File: rtl/player_entry_fifo.sv
// player_entry_fifo: buffers entered digits and replays them oldest-first as spaced load strobes.
module player_entry_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 4,
  parameter int GAP   = 3
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Allow,
  input  logic [DW-1:0]              DigitIn,
  input  logic                       EnterBtn,
  input  logic                       SubmitBtn,
  output logic [DW-1:0]              DigitOut,
  output logic                       DigitValid,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Full,
  output logic                       Empty,
  output logic                       Busy,
  output logic                       OvfErr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {COLLECT, SEND, GAPW} state_t;
  state_t state;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail, headNext;
  logic [3:0] gapCnt;
  logic prevEnter, prevSubmit;
  logic enterPress, submitPress, doWrite, doStart, pop, abort;
  logic [CW-1:0] countNext;
  always_comb begin
    enterPress  = Allow & EnterBtn & ~prevEnter;
    submitPress = Allow & SubmitBtn & ~prevSubmit;
    doWrite     = (state == COLLECT) & enterPress & ~Full;
    doStart     = (state == COLLECT) & submitPress & (~Empty | doWrite);
    pop         = (state == SEND) & Allow;
    abort       = (state != COLLECT) & ~Allow;
    headNext    = head + 1'b1;
    countNext   = abort ? '0 : Count + CW'(doWrite) - CW'(pop);
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= COLLECT;
      head       <= '0;
      tail       <= '0;
      gapCnt     <= '0;
      prevEnter  <= 1'b1;
      prevSubmit <= 1'b1;
      DigitOut   <= '0;
      DigitValid <= 1'b0;
      Count      <= '0;
      Full       <= 1'b0;
      Empty      <= 1'b1;
      Busy       <= 1'b0;
      OvfErr     <= 1'b0;
    end else begin
      prevEnter  <= EnterBtn;
      prevSubmit <= SubmitBtn;
      Count      <= countNext;
      Full       <= countNext == CW'(DEPTH);
      Empty      <= countNext == '0;
      DigitValid <= 1'b0;
      if (doWrite) begin
        mem[tail] <= DigitIn;
        tail      <= tail + 1'b1;
      end
      if ((state == COLLECT) && enterPress && Full) OvfErr <= 1'b1;
      if (abort) begin
        state <= COLLECT;
        head  <= '0;
        tail  <= '0;
        Busy  <= 1'b0;
      end else if (state == COLLECT) begin
        if (doStart) begin
          state      <= SEND;
          Busy       <= 1'b1;
          DigitValid <= 1'b1;
          // a digit entered in the same cycle as submit is not in mem yet
          DigitOut   <= Empty ? DigitIn : mem[head];
        end
      end else if (state == SEND) begin
        head <= headNext;
        if (Count > CW'(1)) begin
          if (GAP == 0) begin
            DigitValid <= 1'b1;
            DigitOut   <= mem[headNext];
          end else begin
            state  <= GAPW;
            gapCnt <= '0;
          end
        end else begin
          state <= COLLECT;
          Busy  <= 1'b0;
        end
      end else if (gapCnt == 4'(GAP - 1)) begin
        state      <= SEND;
        DigitValid <= 1'b1;
        DigitOut   <= mem[head];
      end else begin
        gapCnt <= gapCnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_player_entry_fifo.sv
// tb_player_entry_fifo: directed checks of entry, replay spacing, overflow, abort and reset.
module tb_player_entry_fifo;
  logic Clk = 0, Rst = 1, Allow = 1, EnterBtn = 0, SubmitBtn = 0;
  logic [3:0] DigitIn = 0;
  logic [3:0] DigitOut, DigitOut0;
  logic DigitValid, Full, Empty, Busy, OvfErr;
  logic DigitValid0, Full0, Empty0, Busy0, OvfErr0;
  logic [2:0] Count, Count0;
  int passed = 0, total = 0, n;
  logic [3:0] expq[$];

  always #5 Clk = ~Clk;

  player_entry_fifo #(.DEPTH(4), .DW(4), .GAP(3)) dut (
    .Clk(Clk), .Rst(Rst), .Allow(Allow), .DigitIn(DigitIn), .EnterBtn(EnterBtn),
    .SubmitBtn(SubmitBtn), .DigitOut(DigitOut), .DigitValid(DigitValid), .Count(Count),
    .Full(Full), .Empty(Empty), .Busy(Busy), .OvfErr(OvfErr));

  player_entry_fifo #(.DEPTH(4), .DW(4), .GAP(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Allow(Allow), .DigitIn(DigitIn), .EnterBtn(EnterBtn),
    .SubmitBtn(SubmitBtn), .DigitOut(DigitOut0), .DigitValid(DigitValid0), .Count(Count0),
    .Full(Full0), .Empty(Empty0), .Busy(Busy0), .OvfErr(OvfErr0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    DigitIn = d;
    EnterBtn = 1;
    tick();
    EnterBtn = 0;
    tick();
  endtask

  task automatic submit();
    SubmitBtn = 1;
    tick();
    SubmitBtn = 0;
  endtask

  task automatic doReset();
    Rst = 1;
    EnterBtn = 0;
    SubmitBtn = 0;
    tick();
    tick();
    Rst = 0;
    tick();
  endtask

  // Called in the cycle of the first pulse; z selects the GAP=0 instance.
  task automatic replay(input bit z, input int gap);
    int num = expq.size();
    for (int i = 0; i < num; i++) begin
      if (i > 0) begin
        for (int k = 0; k < gap; k++) begin
          tick();
          chk("gapIdle", z ? DigitValid0 : DigitValid, 0);
          chk("gapBusy", z ? Busy0 : Busy, 1);
        end
        tick();
      end
      chk("pulse", z ? DigitValid0 : DigitValid, 1);
      chk("digit", z ? DigitOut0 : DigitOut, expq[i]);
      chk("pulseCount", z ? Count0 : Count, num - i);
    end
    tick();
    chk("endValid", z ? DigitValid0 : DigitValid, 0);
    chk("endBusy", z ? Busy0 : Busy, 0);
    chk("endCount", z ? Count0 : Count, 0);
    chk("endEmpty", z ? Empty0 : Empty, 1);
    expq.delete();
  endtask

  initial begin
    tick();
    tick();
    chk("rstCount", Count, 0);
    chk("rstEmpty", Empty, 1);
    chk("rstFull", Full, 0);
    chk("rstBusy", Busy, 0);
    chk("rstValid", DigitValid, 0);
    chk("rstOut", DigitOut, 0);
    chk("rstOvf", OvfErr, 0);
    Rst = 0;
    tick();
    press(3); press(7); press(1);
    chk("count3", Count, 3);
    submit();
    expq = '{4'd3, 4'd7, 4'd1};
    replay(0, 3);

    DigitIn = 5;
    EnterBtn = 1;
    repeat (10) tick();
    chk("holdCount", Count, 1);
    EnterBtn = 0;
    tick();
    press(5);
    chk("repressCount", Count, 2);
    submit();
    expq = '{4'd5, 4'd5};
    replay(0, 3);

    doReset();
    press(1); press(2); press(3); press(4);
    chk("fullFlag", Full, 1);
    chk("noOvfYet", OvfErr, 0);
    press(5);
    chk("ovfCount", Count, 4);
    chk("ovfFull", Full, 1);
    chk("ovfErr", OvfErr, 1);
    submit();
    expq = '{4'd1, 4'd2, 4'd3, 4'd4};
    replay(0, 3);
    chk("ovfSticky", OvfErr, 1);

    submit();
    chk("emptySubValid", DigitValid, 0);
    chk("emptySubBusy", Busy, 0);
    tick();
    chk("emptySubBusy2", Busy, 0);
    DigitIn = 9;
    EnterBtn = 1;
    SubmitBtn = 1;
    tick();
    EnterBtn = 0;
    SubmitBtn = 0;
    expq = '{4'd9};
    replay(0, 3);

    doReset();
    press(6); press(2); press(8); press(4);
    submit();
    chk("abortP1", DigitOut, 6);
    repeat (4) tick();
    chk("abortP2", DigitValid, 1);
    chk("abortP2d", DigitOut, 2);
    Allow = 0;
    tick();
    chk("abortCount", Count, 0);
    chk("abortEmpty", Empty, 1);
    chk("abortBusy", Busy, 0);
    chk("abortValid", DigitValid, 0);
    n = 0;
    repeat (10) begin tick(); n += int'(DigitValid); end
    chk("abortNoPulse", n, 0);
    press(5);
    chk("lockEnter", Count, 0);
    submit();
    chk("lockSubmit", Busy, 0);
    Allow = 1;
    tick();
    press(1); press(2);
    Allow = 0;
    press(3);
    repeat (3) tick();
    chk("retainCount", Count, 2);
    Allow = 1;

    Rst = 1;
    DigitIn = 7;
    EnterBtn = 1;
    tick(); tick();
    Rst = 0;
    repeat (3) tick();
    chk("heldThruRst", Count, 0);
    EnterBtn = 0;
    tick();
    press(1); press(2);
    submit();
    chk("gRstP1", DigitValid, 1);
    tick();
    chk("gRstGapw", Busy, 1);
    Rst = 1;
    tick();
    chk("gRstCount", Count, 0);
    chk("gRstBusy", Busy, 0);
    chk("gRstValid", DigitValid, 0);
    chk("gRstOut", DigitOut, 0);
    chk("gRstEmpty", Empty, 1);
    Rst = 0;
    n = 0;
    repeat (10) begin tick(); n += int'(DigitValid); end
    chk("gRstNoPulse", n, 0);
    press(4); press(11);
    chk("g0Count", Count0, 2);
    submit();
    expq = '{4'd4, 4'd11};
    replay(1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
